// File: rtl/reg_dump_pkg.sv
// Shared constants and FSM encoding for the register-dump stream engine.
package reg_dump_pkg;

  localparam logic [7:0] SYNC_BYTE     = 8'hA5;
  localparam int         BYTES_PER_REG = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    LOAD = 3'd2,
    ADDR = 3'd3,
    DATA = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/reg_dump_tx_if.sv
// Byte stream carrying the register dump toward the UART; valid/ready handshake.
interface reg_dump_tx_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/reg_dump_tx_word_serializer.sv
// Holds one 32-bit register value and presents it MSB byte first; each shift
// advances to the next byte, and last flags the final byte of the word.
module word_serializer
  import reg_dump_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        shift,
  output logic [7:0]  msb_byte,
  output logic        last
);

  localparam int CNT_W = $clog2(BYTES_PER_REG);

  logic [31:0]      data_q;
  logic [CNT_W-1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      data_q   <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      data_q   <= word;
      byte_cnt <= '0;
    end else if (shift) begin
      data_q   <= {data_q[23:0], 8'h00};
      byte_cnt <= byte_cnt + 1'b1;
    end
  end

  assign msb_byte = data_q[31:24];
  assign last     = (byte_cnt == CNT_W'(BYTES_PER_REG - 1));

endmodule

// File: rtl/reg_dump_tx.sv
// Walks every register through the debug read port and streams a framed dump:
// sync byte, then per register its index followed by its 4 data bytes MSB first.
module reg_dump_tx #(
  parameter int         NUM_REGS  = 32,
  parameter int         ADDR_W    = 5,
  parameter int         DATA_W    = 32,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  reg_dump_tx_if.master     tx
);

  import reg_dump_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] idx, idx_d;
  logic              hs;
  logic              ser_load, ser_shift, ser_last;
  logic [7:0]        ser_byte;

  word_serializer u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (ser_load),
    .word     (rd_data),
    .shift    (ser_shift),
    .msb_byte (ser_byte),
    .last     (ser_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  assign hs      = tx.tx_valid & tx.tx_ready;
  assign rd_addr = idx;

  // Outputs decode from state only, so tx_valid/tx_data hold steady until accepted.
  always_comb begin
    state_d     = state;
    idx_d       = idx;
    tx.tx_valid = 1'b0;
    tx.tx_data  = 8'h00;
    ser_load    = 1'b0;
    ser_shift   = 1'b0;
    done        = 1'b0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = SYNC_BYTE;
        if (hs) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        ser_load = 1'b1;
        state_d  = ADDR;
      end
      ADDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = 8'(idx);
        if (hs) state_d = DATA;
      end
      DATA: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = ser_byte;
        if (hs) begin
          ser_shift = 1'b1;
          if (ser_last) begin
            if (idx == LAST_IDX) begin
              state_d = DONE;
            end else begin
              idx_d   = idx + 1'b1;
              state_d = LOAD;
            end
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Directed bench: expected frames queued at stimulus time, popped on each handshake.
module tb_reg_dump_tx;
  import reg_dump_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, busy_a, done_a, rdy_a;
  logic        rst_b, start_b, busy_b, done_b, rdy_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] rdat_a, rdat_b;
  logic [31:0] regs_a [32];
  logic [31:0] regs_b [32];

  reg_dump_tx_if if_a ();
  reg_dump_tx_if if_b ();

  assign rdat_a        = regs_a[addr_a];
  assign rdat_b        = regs_b[addr_b];
  assign if_a.tx_ready = rdy_a;
  assign if_b.tx_ready = rdy_b;

  reg_dump_tx dut_a (
    .clk(clk), .reset(rst_a), .start(start_a), .busy(busy_a), .done(done_a),
    .rd_addr(addr_a), .rd_data(rdat_a), .tx(if_a.master)
  );

  reg_dump_tx #(.NUM_REGS(4)) dut_b (
    .clk(clk), .reset(rst_b), .start(start_b), .busy(busy_b), .done(done_b),
    .rd_addr(addr_b), .rd_data(rdat_b), .tx(if_b.master)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ndone_a  = 0;
  int ndone_b  = 0;
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];
  logic       stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] held_a = 8'h00, held_b = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [7:0] b);
    if (sel) q_b.push_back(b);
    else     q_a.push_back(b);
  endtask

  task automatic push_frame(input bit sel, input int nregs);
    logic [31:0] w;
    push(sel, 8'hA5);
    for (int i = 0; i < nregs; i++) begin
      w = sel ? regs_b[i] : regs_a[i];
      push(sel, 8'(i));
      for (int b = 3; b >= 0; b--) push(sel, w[8*b +: 8]);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic set_ready(input bit sel, input logic v);
    if (sel) rdy_b = v;
    else     rdy_a = v;
  endtask

  function automatic logic get_busy(input bit sel);
    return sel ? busy_b : busy_a;
  endfunction

  function automatic logic get_done(input bit sel);
    return sel ? done_b : done_a;
  endfunction

  // Start pulse, then run until done; edge n=1 is the edge that samples start.
  task automatic run_dump(input bit sel, input bit rand_rdy, input int poke1,
                          input int poke2, output int done_at);
    logic busy_ok;
    busy_ok = 1'b1;
    done_at = -1;
    @(posedge clk); #1;
    set_start(sel, 1'b1);
    for (int n = 1; n <= 3000 && done_at < 0; n++) begin
      @(posedge clk); #1;
      set_start(sel, 1'b0);
      set_ready(sel, rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      if (n == poke1) regs_a[5] = 32'h0000_0000;
      if (n == poke2) regs_a[5] = 32'h1234_5678;
      @(negedge clk);
      if (!get_busy(sel)) busy_ok = 1'b0;
      if (get_done(sel)) done_at = n;
    end
    chk("busy_during_dump", busy_ok, 1'b1);
    set_ready(sel, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_done", get_busy(sel), 1'b0);
    chk("frame_fully_sent", sel ? q_b.size() : q_a.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_a) begin
      if (stall_a) begin
        chk("a_hold_valid", if_a.tx_valid, 1'b1);
        chk("a_hold_data", if_a.tx_data, held_a);
      end
      if (if_a.tx_valid && if_a.tx_ready) begin
        if (q_a.size() == 0) chk("a_extra_byte", q_a.size(), 1);
        else chk("a_byte", if_a.tx_data, q_a.pop_front());
      end
      stall_a = if_a.tx_valid && !if_a.tx_ready;
      held_a  = if_a.tx_data;
    end else begin
      stall_a = 1'b0;
    end
    if (rst_b) begin
      if (stall_b) chk("b_hold_data", if_b.tx_data, held_b);
      if (if_b.tx_valid && if_b.tx_ready) begin
        if (q_b.size() == 0) chk("b_extra_byte", q_b.size(), 1);
        else chk("b_byte", if_b.tx_data, q_b.pop_front());
      end
      stall_b = if_b.tx_valid && !if_b.tx_ready;
      held_b  = if_b.tx_data;
    end else begin
      stall_b = 1'b0;
    end
    if (done_a) ndone_a++;
    if (done_b) ndone_b++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d, nd0, dn;
    rst_a = 1'b0; rst_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    rdy_a = 1'b1; rdy_b = 1'b1;
    for (int i = 0; i < 32; i++) begin
      regs_a[i] = 32'h1000_0000 + i;
      regs_b[i] = 32'h1000_0000 + i;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_done", done_a, 1'b0);
    chk("rst_valid", if_a.tx_valid, 1'b0);
    chk("rst_data", if_a.tx_data, 8'h00);
    chk("rst_addr", addr_a, 5'd0);
    chk("rst_b_valid", if_b.tx_valid, 1'b0);
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;

    // Full dump, always ready.
    nd0 = ndone_a;
    push_frame(0, 32);
    run_dump(0, 1'b0, -1, -1, d);
    chk("done_cycle_32", d, 194);
    chk("done_once", ndone_a - nd0, 1);

    // Random backpressure.
    push_frame(0, 32);
    run_dump(0, 1'b1, -1, -1, d);
    chk("rand_finished", d > 0, 1'b1);

    // Start held high: one frame, restart only after IDLE.
    push_frame(0, 32);
    push_frame(0, 32);
    nd0 = ndone_a;
    dn  = -1;
    @(posedge clk); #1;
    start_a = 1'b1;
    for (int n = 1; n <= 1000 && dn < 0; n++) begin
      @(posedge clk); #1;
      if (n == 300) start_a = 1'b0;
      @(negedge clk);
      if (n == 194) chk("hold_done_194", done_a, 1'b1);
      if (n == 195) chk("hold_idle_195", busy_a, 1'b0);
      if (n == 196) chk("hold_restart_196", busy_a, 1'b1);
      if (n == 300) chk("hold_one_frame", ndone_a - nd0, 1);
      if (n > 300 && done_a) dn = n;
    end
    chk("hold_second_done", dn, 389);
    @(posedge clk); #1;
    chk("hold_frames_sent", q_a.size(), 0);

    // Snapshot: reg5 zeroed before its LOAD (edge 33), changed again after.
    regs_a[5] = 32'h0000_0000;
    push_frame(0, 32);
    regs_a[5] = 32'hDEAD_BEEF;
    run_dump(0, 1'b0, 10, 33, d);
    chk("snap_done", d, 194);
    regs_a[5] = 32'h1000_0005;

    // Reset while byte 2 of register 7 is on the bus.
    push_frame(0, 32);
    @(posedge clk); #1;
    start_a = 1'b1;
    for (int n = 1; n <= 47; n++) begin
      @(posedge clk); #1;
      start_a = 1'b0;
    end
    rst_a = 1'b0;
    @(negedge clk);
    chk("mid_word_data", if_a.tx_data, 8'h00);
    chk("mid_bytes_left", q_a.size(), 123);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mrst_valid", if_a.tx_valid, 1'b0);
    chk("mrst_busy", busy_a, 1'b0);
    chk("mrst_done", done_a, 1'b0);
    chk("mrst_addr", addr_a, 5'd0);
    @(posedge clk); #1;
    rst_a = 1'b1;
    q_a.delete();
    push_frame(0, 32);
    run_dump(0, 1'b0, -1, -1, d);
    chk("after_rst_done", d, 194);

    // Four-register instance.
    nd0 = ndone_b;
    push_frame(1, 4);
    run_dump(1, 1'b0, -1, -1, d);
    chk("done_cycle_4", d, 26);
    chk("b_done_once", ndone_b - nd0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
